// File: rtl/ex_issue_ctrl_if.sv
// Decode / execute / memory-stage handshake bundle for the execution issue controller.
// master = the side driving decode and memory-stage inputs; slave = the controller.
interface ex_issue_ctrl_if;
  logic        id_valid;
  logic [1:0]  id_op_class;
  logic        id_ready;
  logic        flush;
  logic        ex_issue;
  logic        ex_busy;
  logic [5:0]  ex_cnt;
  logic        ex_result_valid;
  logic        mem_ready;
  logic        err_illegal;
  logic [15:0] stall_cycles;

  modport master (
    output id_valid, id_op_class, flush, mem_ready,
    input  id_ready, ex_issue, ex_busy, ex_cnt, ex_result_valid, err_illegal, stall_cycles
  );

  modport slave (
    input  id_valid, id_op_class, flush, mem_ready,
    output id_ready, ex_issue, ex_busy, ex_cnt, ex_result_valid, err_illegal, stall_cycles
  );
endinterface

// File: rtl/ex_issue_ctrl.sv
// Execution-stage issue controller: accepts ops from decode, sequences ALU/MUL/DIV latency,
// stalls decode while an op is in flight and hands results to the memory stage.
module ex_issue_ctrl #(
  parameter int MUL_LATENCY = 3,
  parameter int DIV_LATENCY = 33
) (
  input logic           clk,
  input logic           rst_n,
  ex_issue_ctrl_if.slave bus
);

  if (MUL_LATENCY < 1 || MUL_LATENCY > 63) begin : g_bad_mul
    $error("ex_issue_ctrl: MUL_LATENCY must be in 1..63");
  end
  if (DIV_LATENCY < 1 || DIV_LATENCY > 63) begin : g_bad_div
    $error("ex_issue_ctrl: DIV_LATENCY must be in 1..63");
  end

  localparam logic [1:0] CLS_ALU = 2'd0;
  localparam logic [1:0] CLS_MUL = 2'd1;
  localparam logic [1:0] CLS_DIV = 2'd2;
  localparam logic [1:0] CLS_RSV = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [15:0] stall_q, stall_d;

  logic        ready;
  logic        accept;
  logic [5:0]  lat;

  // Class 3 is executed as a single-cycle ALU op; it only raises err_illegal.
  always_comb begin
    lat = 6'd1;
    unique case (bus.id_op_class)
      CLS_MUL: lat = 6'(MUL_LATENCY);
      CLS_DIV: lat = 6'(DIV_LATENCY);
      CLS_ALU,
      CLS_RSV: lat = 6'd1;
      default: lat = 6'd1;
    endcase
  end

  // DONE with mem_ready frees the slot in the same cycle, giving back-to-back issue.
  assign ready  = rst_n & ~bus.flush &
                  ((state_q == S_IDLE) | ((state_q == S_DONE) & bus.mem_ready));
  assign accept = bus.id_valid & ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    stall_d = stall_q;

    if (bus.id_valid && !ready && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;

    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = 6'd0;
    end else if (accept) begin
      if (bus.id_op_class == CLS_RSV)
        err_d = 1'b1;
      if (lat == 6'd1) begin
        state_d = S_DONE;
        cnt_d   = 6'd0;
      end else begin
        state_d = S_EXEC;
        cnt_d   = lat - 6'd1;
      end
    end else begin
      unique case (state_q)
        S_EXEC: begin
          if (cnt_q == 6'd1) begin
            state_d = S_DONE;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        S_DONE: begin
          if (bus.mem_ready)
            state_d = S_IDLE;
        end
        S_IDLE: ;
        default: begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      err_q   <= 1'b0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  // A flush discards a waiting result even when memory is ready to take it.
  assign bus.id_ready        = ready;
  assign bus.ex_issue        = accept;
  assign bus.ex_busy         = (state_q != S_IDLE);
  assign bus.ex_cnt          = cnt_q;
  assign bus.ex_result_valid = (state_q == S_DONE) & ~bus.flush;
  assign bus.err_illegal     = err_q;
  assign bus.stall_cycles    = stall_q;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Directed bench for ex_issue_ctrl: inputs change 1ns after posedge, outputs sampled on negedge.
module tb_ex_issue_ctrl;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  ex_issue_ctrl_if bus ();

  ex_issue_ctrl #(.MUL_LATENCY(3), .DIV_LATENCY(33)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [1:0] cls, input logic mr, input logic fl);
    bus.id_valid    = v;
    bus.id_op_class = cls;
    bus.mem_ready   = mr;
    bus.flush       = fl;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    drv(1'b1, 2'd0, 1'b1, 1'b0);

    // reset: everything low, even with decode offering an op
    #12;
    chk("rst_ready", 32'(bus.id_ready), 32'd0);
    chk("rst_issue", 32'(bus.ex_issue), 32'd0);
    chk("rst_busy",  32'(bus.ex_busy), 32'd0);
    chk("rst_rv",    32'(bus.ex_result_valid), 32'd0);
    chk("rst_cnt",   32'(bus.ex_cnt), 32'd0);
    chk("rst_err",   32'(bus.err_illegal), 32'd0);
    chk("rst_stall", 32'(bus.stall_cycles), 32'd0);
    nxt();
    rst_n = 1'b1;

    // four back-to-back ALU ops
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 2'd0, 1'b1, 1'b0);
      mid();
      chk("alu_ready", 32'(bus.id_ready), 32'd1);
      chk("alu_issue", 32'(bus.ex_issue), 32'd1);
      chk("alu_rv",    32'(bus.ex_result_valid), (k > 0) ? 32'd1 : 32'd0);
      nxt();
    end
    drv(1'b0, 2'd0, 1'b1, 1'b0);
    mid();
    chk("alu_rv_last", 32'(bus.ex_result_valid), 32'd1);
    chk("alu_noissue", 32'(bus.ex_issue), 32'd0);
    nxt();
    mid();
    chk("alu_rv_off", 32'(bus.ex_result_valid), 32'd0);
    chk("alu_idle",   32'(bus.ex_busy), 32'd0);
    chk("alu_stall",  32'(bus.stall_cycles), 32'd0);
    nxt();

    // DIV with id_valid held: 32 stall cycles, result at t+33, next DIV issued then
    drv(1'b1, 2'd2, 1'b1, 1'b0);
    mid();
    chk("div_issue", 32'(bus.ex_issue), 32'd1);
    nxt();
    for (int k = 1; k <= 32; k++) begin
      mid();
      chk("div_ready", 32'(bus.id_ready), 32'd0);
      chk("div_cnt",   32'(bus.ex_cnt), 32'(33 - k));
      chk("div_rv",    32'(bus.ex_result_valid), 32'd0);
      nxt();
    end
    mid();
    chk("div_rv_t33",  32'(bus.ex_result_valid), 32'd1);
    chk("div_b2b",     32'(bus.ex_issue), 32'd1);
    chk("div_stall",   32'(bus.stall_cycles), 32'd32);
    nxt();

    // second DIV flushed at ex_cnt = 10
    for (int k = 1; k <= 22; k++) begin
      mid();
      chk("div2_cnt", 32'(bus.ex_cnt), 32'(33 - k));
      nxt();
    end
    drv(1'b1, 2'd0, 1'b1, 1'b1);
    mid();
    chk("fl_cnt10",  32'(bus.ex_cnt), 32'd10);
    chk("fl_ready",  32'(bus.id_ready), 32'd0);
    chk("fl_issue",  32'(bus.ex_issue), 32'd0);
    chk("fl_rv",     32'(bus.ex_result_valid), 32'd0);
    nxt();
    drv(1'b1, 2'd0, 1'b1, 1'b0);
    mid();
    chk("fl_idle",   32'(bus.ex_busy), 32'd0);
    chk("fl_cnt0",   32'(bus.ex_cnt), 32'd0);
    chk("fl_rv_after", 32'(bus.ex_result_valid), 32'd0);
    chk("fl_newop",  32'(bus.ex_issue), 32'd1);
    chk("fl_stall",  32'(bus.stall_cycles), 32'd55);
    nxt();
    drv(1'b0, 2'd0, 1'b1, 1'b0);
    mid();
    chk("fl_op_rv", 32'(bus.ex_result_valid), 32'd1);
    nxt();
    mid();
    chk("fl_op_idle", 32'(bus.ex_busy), 32'd0);
    nxt();

    // MUL held in DONE by memory backpressure, then ALU issued the release cycle
    drv(1'b1, 2'd1, 1'b0, 1'b0);
    mid();
    chk("mul_issue", 32'(bus.ex_issue), 32'd1);
    nxt();
    drv(1'b1, 2'd0, 1'b0, 1'b0);
    for (int k = 2; k >= 1; k--) begin
      mid();
      chk("mul_cnt",   32'(bus.ex_cnt), 32'(k));
      chk("mul_ready", 32'(bus.id_ready), 32'd0);
      nxt();
    end
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("mul_hold_rv",    32'(bus.ex_result_valid), 32'd1);
      chk("mul_hold_ready", 32'(bus.id_ready), 32'd0);
      nxt();
    end
    drv(1'b1, 2'd0, 1'b1, 1'b0);
    mid();
    chk("mul_rel_ready", 32'(bus.id_ready), 32'd1);
    chk("mul_rel_issue", 32'(bus.ex_issue), 32'd1);
    chk("mul_rel_rv",    32'(bus.ex_result_valid), 32'd1);
    chk("mul_stall",     32'(bus.stall_cycles), 32'd62);
    nxt();
    drv(1'b0, 2'd0, 1'b1, 1'b0);
    mid();
    chk("mul_alu_rv", 32'(bus.ex_result_valid), 32'd1);
    nxt();
    mid();
    chk("mul_idle", 32'(bus.ex_busy), 32'd0);
    nxt();

    // flush in DONE discards result; class-3 op then runs as ALU and sets err
    drv(1'b1, 2'd0, 1'b1, 1'b0);
    mid();
    chk("fd_issue", 32'(bus.ex_issue), 32'd1);
    nxt();
    drv(1'b1, 2'd3, 1'b1, 1'b1);
    mid();
    chk("fd_rv",    32'(bus.ex_result_valid), 32'd0);
    chk("fd_issue0", 32'(bus.ex_issue), 32'd0);
    chk("fd_busy",  32'(bus.ex_busy), 32'd1);
    nxt();
    drv(1'b1, 2'd3, 1'b1, 1'b0);
    mid();
    chk("c3_issue", 32'(bus.ex_issue), 32'd1);
    chk("c3_err0",  32'(bus.err_illegal), 32'd0);
    chk("c3_idle",  32'(bus.ex_busy), 32'd0);
    nxt();
    drv(1'b0, 2'd0, 1'b1, 1'b0);
    mid();
    chk("c3_rv",    32'(bus.ex_result_valid), 32'd1);
    chk("c3_err1",  32'(bus.err_illegal), 32'd1);
    chk("c3_stall", 32'(bus.stall_cycles), 32'd63);
    nxt();
    mid();
    chk("c3_err_sticky", 32'(bus.err_illegal), 32'd1);
    nxt();

    // reset clears counter, then saturate it with flush held against a pending op
    rst_n = 1'b0;
    #1;
    chk("rp_stall", 32'(bus.stall_cycles), 32'd0);
    chk("rp_err",   32'(bus.err_illegal), 32'd0);
    nxt();
    rst_n = 1'b1;
    drv(1'b1, 2'd2, 1'b1, 1'b1);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_pre", 32'(bus.stall_cycles), 32'd65534);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_hold", 32'(bus.stall_cycles), 32'hFFFF);

    // reset mid-EXEC
    drv(1'b1, 2'd2, 1'b1, 1'b0);
    mid();
    chk("re_issue", 32'(bus.ex_issue), 32'd1);
    nxt();
    drv(1'b0, 2'd0, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("re_cnt",  32'(bus.ex_cnt), 32'd28);
    chk("re_busy", 32'(bus.ex_busy), 32'd1);
    drv(1'b1, 2'd0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("re_ready", 32'(bus.id_ready), 32'd0);
    chk("re_issue0", 32'(bus.ex_issue), 32'd0);
    chk("re_busy0", 32'(bus.ex_busy), 32'd0);
    chk("re_rv",    32'(bus.ex_result_valid), 32'd0);
    chk("re_cnt0",  32'(bus.ex_cnt), 32'd0);
    chk("re_stall", 32'(bus.stall_cycles), 32'd0);
    nxt();
    rst_n = 1'b1;
    drv(1'b0, 2'd0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("re_after_busy", 32'(bus.ex_busy), 32'd0);
      chk("re_after_rv",   32'(bus.ex_result_valid), 32'd0);
      nxt();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ex_issue_ctrl.md
# ex_issue_ctrl

Issue and sequencing controller for the execution stage. It accepts operations from decode with a valid/ready handshake and pulses the capture enable for the execution-stage operand and control registers. It tracks per-class latency (single-cycle ALU, iterative multiply, iterative divide), stalls decode while a multi-cycle operation is in flight, and presents results to the memory stage with a valid/ready handshake. Branch-resolution flushes kill any in-flight operation.

## Interface
- MUL_LATENCY, 3, cycles from accept to result valid for multiply class (legal 1..63)
- DIV_LATENCY, 33, cycles from accept to result valid for divide class (legal 1..63)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- id_valid  in  1  decode presents an operation
- id_op_class  in  2  0 = ALU (latency 1), 1 = MUL, 2 = DIV, 3 = reserved
- id_ready  out  1  controller accepts the operation this cycle
- flush  in  1  kill in-flight operation (branch mispredict)
- ex_issue  out  1  one-cycle capture enable for data1/data2/immediate_data/control_in/program_counter registers
- ex_busy  out  1  operation in flight (EXEC or DONE)
- ex_cnt  out  6  remaining cycles before result valid, 0 outside EXEC
- ex_result_valid  out  1  result (alu_data, flags, control_out) valid to memory stage
- mem_ready  in  1  memory stage accepts result
- err_illegal  out  1  sticky, class 3 seen on an accepted operation
- stall_cycles  out  16  saturating count of cycles with id_valid=1 and id_ready=0

## Operation
- States: IDLE, EXEC, DONE. Reset state IDLE.
- id_ready = rst_n & ~flush & (IDLE | (DONE & mem_ready)).
- Accept = id_valid & id_ready; ex_issue = accept (combinational, same cycle).
- Latency L on accept: ALU 1, MUL MUL_LATENCY, DIV DIV_LATENCY, class 3 treated as ALU and sets err_illegal.
- On accept: L = 1 -> DONE, ex_cnt <= 0; L > 1 -> EXEC, ex_cnt <= L-1.
- EXEC: ex_cnt decrements each cycle; when ex_cnt = 1 -> DONE, ex_cnt <= 0.
- DONE: ex_result_valid = 1 until mem_ready. On mem_ready without a new accept -> IDLE. On mem_ready with a new accept -> load the new operation (back-to-back, no bubble).
- flush (any state) takes priority over everything: next state IDLE, ex_cnt <= 0, no accept, ex_result_valid forced 0 in the flush cycle. A result in DONE is discarded even if mem_ready = 1.
- ex_busy = EXEC | DONE.
- stall_cycles increments when id_valid & ~id_ready, including flush cycles. It saturates at 0xFFFF and is cleared only by reset.
- err_illegal is set on an accepted class-3 operation, held until reset, and is not set by a flushed (unaccepted) operation.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, ex_cnt 0, err_illegal 0, stall_cycles 0, and all outputs 0, including id_ready, ex_issue, ex_busy and ex_result_valid.
- Accept in cycle t gives ex_result_valid high from cycle t+L.
- Sustained throughput with mem_ready held high: 1 op/cycle for ALU, 1 op per L cycles for MUL/DIV.
- Reset deasserted mid-operation: controller restarts in IDLE, with no residual result.
- Parameter values outside 1..63 are illegal; an assertion fires at elaboration.

## Test plan
- Reset, then ALU ops on 4 consecutive cycles with mem_ready = 1 -> id_ready stays 1, ex_issue pulses 4 times, ex_result_valid high cycles t+1..t+4, stall_cycles = 0.
- DIV accepted at t with DIV_LATENCY = 33 and id_valid held -> id_ready 0 for t+1..t+32, ex_cnt 32 at t+1 down to 1 at t+32, ex_result_valid at t+33, stall_cycles = 32.
- MUL reaches DONE with mem_ready = 0 for 5 cycles -> ex_result_valid held 5 cycles, id_ready 0. mem_ready = 1 with id_valid = 1 (ALU) -> accept in the same cycle, next result valid the following cycle.
- flush at ex_cnt = 10 during DIV -> IDLE next cycle, ex_cnt 0, no ex_result_valid; a new op accepted the cycle after flush.
- flush in DONE with mem_ready = 1 -> ex_result_valid 0 that cycle, no accept; class-3 op accepted afterwards -> err_illegal = 1 and behaves as ALU (result at t+1).
- Force stall_cycles near saturation via a long DIV chain -> count stops at 0xFFFF. rst_n pulse mid-EXEC -> all outputs 0 immediately and counter cleared.
